// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus after a stability window.
// Optional decimal-point capture on dp_out is enabled with `define SEG_DP_CAPTURE_EN.
module seg_digit_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [3:0] code,
    output logic [3:0] nib,
    output logic       vld
);
    always_ff @(posedge clk) begin
        if (rst) begin
            nib <= '0;
            vld <= 1'b0;
        end else if (wr) begin
            nib <= code;
            vld <= 1'b1;
        end
    end
endmodule

module seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGITS-1:0]   an,
    input  logic [7:0]          seg,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                frame_done,
    output logic                err,
    output logic [7:0]          err_pattern
`ifdef SEG_DP_CAPTURE_EN
    ,
    output logic [DIGITS-1:0]   dp_out
`endif
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    typedef struct packed {
        logic [DIGITS-1:0] an;
        logic [7:0]        seg;
    } samp_t;

    function automatic logic [4:0] seg_dec(input logic [6:0] p);
        case (p)
            7'h40: seg_dec = 5'h10;
            7'h79: seg_dec = 5'h11;
            7'h24: seg_dec = 5'h12;
            7'h30: seg_dec = 5'h13;
            7'h19: seg_dec = 5'h14;
            7'h12: seg_dec = 5'h15;
            7'h02: seg_dec = 5'h16;
            7'h78: seg_dec = 5'h17;
            7'h00: seg_dec = 5'h18;
            7'h18: seg_dec = 5'h19;
            7'h08: seg_dec = 5'h1A;
            7'h03: seg_dec = 5'h1B;
            7'h46: seg_dec = 5'h1C;
            7'h21: seg_dec = 5'h1D;
            7'h06: seg_dec = 5'h1E;
            7'h0E: seg_dec = 5'h1F;
            default: seg_dec = 5'h00;
        endcase
    endfunction

    samp_t             cur, samp;
    logic [CW-1:0]     cnt;
    logic              match, commit, onehot, good, bad;
    logic [DIGITS-1:0] sel, wr_en, seen, seen_nxt;
    logic [4:0]        dec;
    logic [DIGITS-1:0][3:0] nib_a;

    assign cur   = {an, seg};
    assign match = (cur == samp);

    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= '1;
            cnt  <= '0;
        end else begin
            samp <= cur;
            if (!match)
                cnt <= '0;
            else if (cnt != CMAX)
                cnt <= cnt + 1'b1;
        end
    end

    // One commit per window: the edge on which the count leaves STABLE_CYCLES-1.
    assign commit   = match && (cnt == CMAX - 1'b1);
    assign sel      = ~samp.an;
    assign onehot   = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign dec      = seg_dec(samp.seg[6:0]);
    assign good     = commit && onehot && dec[4];
    assign bad      = commit && (sel != '0) && !(onehot && dec[4]);
    assign wr_en    = good ? sel : '0;
    assign seen_nxt = seen | wr_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
        seg_digit_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .wr   (wr_en[i]),
            .code (dec[3:0]),
            .nib  (nib_a[i]),
            .vld  (digit_valid[i])
        );
    end
    assign value = nib_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen        <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            err_pattern <= 8'hFF;
        end else begin
            frame_done <= 1'b0;
            err        <= bad;
            if (bad)
                err_pattern <= samp.seg;
            if (good) begin
                if (&seen_nxt) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst)
            dp_out <= '0;
        else
            for (int i = 0; i < DIGITS; i++)
                if (wr_en[i]) dp_out[i] <= ~samp.seg[7];
    end
`endif
endmodule
